branch_target_buffer: RTL
=========================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped entries; power of two, 4..64.
REQ-002 Parameter CTR_INIT, default 2'b10, counter value loaded on allocation (weakly taken).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lookup_pc  input  16  PC presently held by fetch.
REQ-006 predicted_pc  output  16  next fetch address, combinational from lookup_pc and current state.
REQ-007 hit  output  1  lookup_pc matches a valid entry, combinational.
REQ-008 update_en  input  1  resolved jump retiring from writeback this cycle.
REQ-009 update_pc  input  16  PC of the retiring jump.
REQ-010 update_target  input  16  resolved next PC of the retiring jump (target if taken, pc+2 otherwise).
REQ-011 update_taken  input  1  retiring jump was taken.

Function
REQ-012 Index = pc[IDX+0:1] with IDX = log2(ENTRIES); tag = pc[15:IDX+1]; pc[0] ignored for index and tag.
REQ-013 Per entry: valid (1), tag, target (16), 2-bit saturating counter.
REQ-014 hit = valid && tag match at index of lookup_pc; zero-cycle latency.
REQ-015 predicted_pc = target when hit and counter[1]==1, else lookup_pc+2, truncated to 16 bits (0xFFFE -> 0x0000).
REQ-016 Update, update_en=1 and hit at update_pc: taken -> counter+1 saturating at 3, target <= update_target; not taken -> counter-1 saturating at 0, target unchanged.
REQ-017 Update, update_en=1 and miss, taken: allocate (overwrite) indexed entry, valid=1, tag, target=update_target, counter=CTR_INIT.
REQ-018 Update, update_en=1 and miss, not taken: no state change.
REQ-019 update_en=0: no state change.
REQ-020 Lookup and update to the same index in the same cycle: lookup returns pre-update contents; no bypass.
REQ-021 Conflicting tag in same index is evicted only by a taken miss (REQ-017).
REQ-022 Outputs are pure functions of state and lookup_pc; no output register.

Reset
REQ-023 reset=1 at a clock edge clears every valid bit and every counter to 0; tags and targets need not be cleared.
REQ-024 update_en is ignored on any edge where reset=1.
REQ-025 While state is cleared, hit=0 and predicted_pc=lookup_pc+2 for every lookup_pc.
REQ-026 Reset asserted mid-training discards all learned entries; first post-reset edge behaves as REQ-016..019 on empty table.

Structure
REQ-027 Shared package holds PC width (16), fall-through increment (2), counter width (2) and counter encodings (SNT=0, WNT=1, WT=2, ST=3).
REQ-028 One sub-module, btb_sat_counter: 2-bit saturating up/down next-state logic, instantiated once in the update path.
REQ-029 Entry arrays are registers (no memory macro), so lookup stays combinational.

Verification
REQ-030 Reset then lookup_pc=0x0010 -> hit=0, predicted_pc=0x0012; lookup 0xFFFE -> predicted_pc=0x0000.
REQ-031 Update pc=0x0010 target=0x0040 taken; next cycle lookup 0x0010 -> hit=1, predicted_pc=0x0040; lookup 0x0011 -> same.
REQ-032 Train 0x0010 taken x3 (counter 3), then not-taken x1 -> predicted_pc=0x0040; second not-taken -> predicted_pc=0x0012, hit=1.
REQ-033 With 16 entries, 0x0010 trained taken, then update 0x0030 (same index, other tag) taken to 0x0100 -> 0x0010 misses (0x0012), 0x0030 predicts 0x0100; not-taken miss at 0x0050 leaves 0x0030 intact.
REQ-034 Same-cycle update 0x0010 taken and lookup 0x0010 on empty table -> that cycle predicted_pc=0x0012; following cycle 0x0040.
REQ-035 Train several entries, assert reset one cycle together with update_en=1 -> all lookups miss afterwards, the concurrent update is not installed.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared widths and encodings for the branch target buffer.
// Lookup is combinational; updates have no backpressure.
package branch_target_buffer_pkg;

  localparam int PC_W = 16;
  localparam int CTR_W = 2;
  localparam logic [PC_W-1:0] PC_INC = 16'd2;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
// Purely combinational; no handshake.
module btb_sat_counter
  import branch_target_buffer_pkg::*;
(
  input  logic [CTR_W-1:0] ctrCur,
  input  logic             taken,
  output logic [CTR_W-1:0] ctrNext
);

  always_comb begin
    ctrNext = ctrCur;
    if (taken) begin
      if (ctrCur != ST) ctrNext = ctrCur + CTR_W'(1);
    end else begin
      if (ctrCur != SNT) ctrNext = ctrCur - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-cycle lookup of next fetch PC, trained by retiring jumps.
// Updates are always accepted (no backpressure); same-cycle lookups see pre-update state.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int          ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic [PC_W-1:0] predicted_pc,
  output logic            hit,
  input  logic            update_en,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] update_target,
  input  logic            update_taken
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX - 1;

  logic             validQ  [ENTRIES];
  logic [TAG_W-1:0] tagQ    [ENTRIES];
  logic [PC_W-1:0]  targetQ [ENTRIES];
  logic [CTR_W-1:0] ctrQ    [ENTRIES];

  logic [IDX-1:0]   lkIdx;
  logic [TAG_W-1:0] lkTag;
  logic [IDX-1:0]   upIdx;
  logic [TAG_W-1:0] upTag;
  logic             upHit;
  logic [CTR_W-1:0] upCtrNext;
  logic             unusedPcLsb;

  // Bit 0 never participates: instructions are halfword aligned.
  assign lkIdx       = lookup_pc[IDX:1];
  assign lkTag       = lookup_pc[PC_W-1:IDX+1];
  assign upIdx       = update_pc[IDX:1];
  assign upTag       = update_pc[PC_W-1:IDX+1];
  assign unusedPcLsb = update_pc[0];

  assign hit          = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign predicted_pc = (hit && ctrQ[lkIdx][1]) ? targetQ[lkIdx] : lookup_pc + PC_INC;

  assign upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);

  btb_sat_counter uSatCounter (
    .ctrCur  (ctrQ[upIdx]),
    .taken   (update_taken),
    .ctrNext (upCtrNext)
  );

  // Tags and targets are left alone on reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= '0;
      end
    end else if (update_en) begin
      if (upHit) begin
        ctrQ[upIdx] <= upCtrNext;
        if (update_taken) targetQ[upIdx] <= update_target;
      end else if (update_taken) begin
        validQ[upIdx]  <= 1'b1;
        tagQ[upIdx]    <= upTag;
        targetQ[upIdx] <= update_target;
        ctrQ[upIdx]    <= CTR_INIT;
      end
    end
  end

endmodule
